// File: rtl/ycr_wbb_mem_slave.sv
// Burst Wishbone memory responder (bl/bry/lack) with byte enables, word-index
// wrap and out-of-window error reporting. All outputs are registered.
module ycr_wbb_mem_slave #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   BW        = 4,
  parameter int unsigned   BL        = 10,
  parameter int unsigned   MW        = 8,
  parameter logic [AW-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          wbs_clk_i,
  input  logic          wbs_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic          wbs_we_i,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic [BW-1:0] wbs_sel_i,
  input  logic [BL-1:0] wbs_bl_i,
  input  logic          wbs_bry_i,
  output logic [DW-1:0] wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_lack_o,
  output logic          wbs_err_o
);

  localparam int unsigned DEPTH = 2**MW;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t        r_state;
  logic [MW-1:0] r_idx;
  logic [MW-1:0] r_widx;
  logic [BL-1:0] r_rem;
  logic          r_we;
  logic          r_oob;
  logic          r_ack;
  logic          r_lack;
  logic          r_err;
  logic [DW-1:0] r_dat;
  logic [DW-1:0] r_mem [DEPTH];

  logic w_issue;
  logic w_wr;
  logic w_oob;
  logic w_unused_adr;

  assign w_oob   = (wbs_adr_i[AW-1:MW+2] != BASE_ADDR[AW-1:MW+2]);
  assign w_issue = (r_state == S_BURST) & wbs_cyc_i & wbs_stb_i & wbs_bry_i & (r_rem != '0);
  // Writes commit during the ack cycle, so the master's held data is used; an
  // abort (cyc low) or reset in that cycle cancels the pending beat.
  assign w_wr    = r_ack & r_we & ~r_oob & wbs_cyc_i & ~wbs_rst_i;
  assign w_unused_adr = &{1'b0, wbs_adr_i[1:0]};

  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_widx  <= '0;
      r_rem   <= '0;
      r_we    <= 1'b0;
      r_oob   <= 1'b0;
      r_ack   <= 1'b0;
      r_lack  <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_ack  <= 1'b0;
      r_lack <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            r_idx   <= wbs_adr_i[MW+1:2];
            r_we    <= wbs_we_i;
            r_rem   <= (wbs_bl_i == '0) ? BL'(1) : wbs_bl_i;
            r_oob   <= w_oob;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (!wbs_cyc_i) begin
            r_rem   <= '0;
            r_state <= S_IDLE;
          end else if (w_issue) begin
            r_ack  <= 1'b1;
            r_err  <= r_oob;
            r_lack <= (r_rem == BL'(1));
            r_rem  <= r_rem - BL'(1);
            r_idx  <= r_idx + MW'(1);
            r_widx <= r_idx;
            if (!r_we) begin
              r_dat <= r_oob ? '0 : r_mem[r_idx];
            end
            if (r_rem == BL'(1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!wbs_stb_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wbs_clk_i) begin
    if (w_wr) begin
      for (int unsigned b = 0; b < BW; b++) begin
        if (wbs_sel_i[b]) begin
          r_mem[r_widx][b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
        end
      end
    end
  end

  assign wbs_dat_o  = r_dat;
  assign wbs_ack_o  = r_ack;
  assign wbs_lack_o = r_lack;
  assign wbs_err_o  = r_err;

endmodule

// File: tb/tb_ycr_wbb_mem_slave.sv
// Self-checking bench for ycr_wbb_mem_slave: table of bursts, reference memory
// model, and a scoreboard queue of expected beats popped on every ack.
module tb_ycr_wbb_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] adr = '0;
  logic        we  = 1'b0;
  logic [31:0] dati = '0;
  logic [3:0]  sel = '0;
  logic [9:0]  bl  = '0;
  logic        bry = 1'b0;
  logic [31:0] dato;
  logic        ack, lack, err;

  always #5 clk = ~clk;

  ycr_wbb_mem_slave #(.AW(32), .DW(32), .BW(4), .BL(10), .MW(8), .BASE_ADDR(32'h0)) dut (
    .wbs_clk_i(clk), .wbs_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_adr_i(adr), .wbs_we_i(we), .wbs_dat_i(dati), .wbs_sel_i(sel),
    .wbs_bl_i(bl), .wbs_bry_i(bry), .wbs_dat_o(dato), .wbs_ack_o(ack),
    .wbs_lack_o(lack), .wbs_err_o(err)
  );

  typedef struct {
    bit          rd;
    logic [31:0] dat;
    bit          lst;
    bit          er;
  } exp_t;

  typedef struct {
    bit          w;
    logic [31:0] a;
    int          n;
    logic [3:0]  s;
    bit          thr;
    int          abort_at;
    int          rst_at;
    logic [31:0] wbase;
    logic [31:0] wstep;
  } vec_t;

  exp_t        sbq[$];
  logic [31:0] mdl [256];
  vec_t        vt [18];
  int          checks = 0;
  int          failures = 0;
  int          t_cyc = 0;
  int          nack = 0;
  int          first_t = -1;
  bit          got_lack = 1'b0;
  bit          bry_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0d)", name, act, exp, t_cyc);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    t_cyc++;
    if (ack) begin
      nack++;
      if (first_t < 0) first_t = t_cyc;
      chk("bry_before_ack", {31'b0, bry_prev}, 32'd1);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=1 expected=0 (t=%0d)", t_cyc);
      end else begin
        e = sbq.pop_front();
        chk("lack", {31'b0, lack}, {31'b0, e.lst});
        chk("err", {31'b0, err}, {31'b0, e.er});
        if (e.rd) chk("rdata", dato, e.dat);
      end
      got_lack = lack;
    end else begin
      got_lack = 1'b0;
      chk("idle_lack_err", {30'b0, lack, err}, 32'd0);
    end
    bry_prev = bry;
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input vec_t v);
    int          eff, stop, nexp, nwr, n0, done, t_req, it;
    logic [7:0]  idx;
    bit          oob;
    exp_t        e;
    logic [31:0] wd;
    eff  = (v.n == 0) ? 1 : v.n;
    stop = (v.abort_at > 0) ? v.abort_at : v.rst_at;
    nexp = (stop > 0) ? stop : eff;
    nwr  = (stop > 0) ? stop - 1 : eff;
    idx  = v.a[9:2];
    oob  = (v.a[31:10] != 22'd0);
    for (int k = 0; k < nexp; k++) begin
      e.rd  = !v.w;
      e.lst = (k == eff - 1);
      e.er  = oob;
      e.dat = oob ? 32'h0 : mdl[8'(idx + 8'(k))];
      sbq.push_back(e);
    end
    if (v.w && !oob) begin
      for (int k = 0; k < nwr; k++) begin
        wd = v.wbase + 32'(k) * v.wstep;
        for (int b = 0; b < 4; b++)
          if (v.s[b]) mdl[8'(idx + 8'(k))][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    cyc = 1'b1; stb = 1'b1; we = v.w; adr = v.a; bl = v.n[9:0]; sel = v.s;
    dati = v.wbase; bry = 1'b1;
    t_req = t_cyc + 1;
    first_t = -1;
    n0 = nack;
    it = 0;
    forever begin
      tick();
      it++;
      done = nack - n0;
      if (got_lack) begin
        cyc = 1'b0; stb = 1'b0; bry = 1'b0;
        break;
      end
      if (v.abort_at > 0 && done == v.abort_at - 1) begin
        cyc = 1'b0; stb = 1'b0; bry = 1'b0;
        break;
      end
      if (v.rst_at > 0 && done == v.rst_at - 1) begin
        rst = 1'b1;
        break;
      end
      if (it > 60) begin
        checks++;
        failures++;
        $display("FAIL burst_timeout actual=%0d expected=%0d acks", done, nexp);
        cyc = 1'b0; stb = 1'b0; bry = 1'b0;
        break;
      end
      dati = v.wbase + 32'(done) * v.wstep;
      bry  = v.thr ? ~bry : 1'b1;
    end
    tick();
    if (stop > 0) begin
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; bry = 1'b0;
      chk("after_stop_outputs", {29'b0, ack, lack, err}, 32'd0);
    end
    tick();
    tick();
    if (!v.thr) chk("first_ack_latency", 32'(first_t - t_req), 32'd2);
    chk("beats_acked", 32'(nack - n0), 32'(nexp));
    chk("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    //            w  adr           n  sel   thr ab rs wbase          wstep
    vt[0]  = '{1'b1, 32'h0000_0010, 1, 4'hF, 1'b0, 0, 0, 32'hDEAD_BEEF, 32'd0};
    vt[1]  = '{1'b0, 32'h0000_0010, 1, 4'hF, 1'b0, 0, 0, 32'h0,         32'd0};
    vt[2]  = '{1'b1, 32'h0000_0040, 8, 4'hF, 1'b0, 0, 0, 32'h0,         32'd1};
    vt[3]  = '{1'b0, 32'h0000_0040, 8, 4'hF, 1'b0, 0, 0, 32'h0,         32'd0};
    vt[4]  = '{1'b0, 32'h0000_0040, 4, 4'hF, 1'b1, 0, 0, 32'h0,         32'd0};
    vt[5]  = '{1'b1, 32'h0000_03FC, 1, 4'hF, 1'b0, 0, 0, 32'hFFFF_FFFF, 32'd0};
    vt[6]  = '{1'b1, 32'h0000_0000, 1, 4'hF, 1'b0, 0, 0, 32'hFFFF_FFFF, 32'd0};
    vt[7]  = '{1'b1, 32'h0000_03FC, 2, 4'h3, 1'b0, 0, 0, 32'h1234_5678, 32'd0};
    vt[8]  = '{1'b0, 32'h0000_03FC, 2, 4'hF, 1'b0, 0, 0, 32'h0,         32'd0};
    vt[9]  = '{1'b1, 32'h0000_0400, 3, 4'hF, 1'b0, 0, 0, 32'hA5A5_0000, 32'd1};
    vt[10] = '{1'b0, 32'h0000_0400, 3, 4'hF, 1'b0, 0, 0, 32'h0,         32'd0};
    vt[11] = '{1'b0, 32'h0000_03FC, 2, 4'hF, 1'b0, 0, 0, 32'h0,         32'd0};
    vt[12] = '{1'b0, 32'h0000_0040, 6, 4'hF, 1'b0, 2, 0, 32'h0,         32'd0};
    vt[13] = '{1'b0, 32'h0000_0044, 0, 4'hF, 1'b0, 0, 0, 32'h0,         32'd0};
    vt[14] = '{1'b1, 32'h0000_0100, 4, 4'hF, 1'b0, 0, 0, 32'h1111_0000, 32'd1};
    vt[15] = '{1'b1, 32'h0000_0100, 4, 4'hF, 1'b0, 0, 2, 32'h5500_0000, 32'd1};
    vt[16] = '{1'b0, 32'h0000_0100, 4, 4'hF, 1'b0, 0, 0, 32'h0,         32'd0};
    vt[17] = '{1'b0, 32'h0000_0010, 1, 4'hF, 1'b0, 0, 0, 32'h0,         32'd0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outputs", {29'b0, ack, lack, err}, 32'd0);
    chk("reset_dat_o", dato, 32'h0);
    tick();

    for (int i = 0; i < 18; i++) burst(vt[i]);

    // Hand-written check of the wrap/byte-enable result against fixed values.
    chk("wrap_word255", mdl[255], 32'hFFFF_5678);
    chk("wrap_word0", mdl[0], 32'hFFFF_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
